wb_stage_p: RTL and testbench
=============================

# wb_stage_p

Parametrised writeback stage: the MEM/WB pipeline register plus writeback-data formation, between the memory stage and the register-file write port. It adds per-stage valid tracking, stall/flush control, and sub-word load extraction with sign/zero extension. It also detects misaligned loads and keeps a saturating retired-instruction counter. Instruction tracking tags (type/number) ride alongside for the debug display.

## Interface

- DATA_W, 32: datapath width; legal values 32 or 64.
- REG_AW, 5: register index width.
- TYPE_W, 4: instruction-type tag width.
- NUM_W, 4: instruction-number tag width.
- CNT_W, 16: retire counter width.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived; not overridden).

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_destR  in  REG_AW  destination register index.
- mem_aluR  in  DATA_W  ALU result; the low OFF_W bits are the load byte offset.
- mem_mdata  in  DATA_W  raw memory read word.
- mem_wreg  in  1  instruction writes a register.
- mem_m2reg  in  1  select memory data (1) or ALU result (0).
- mem_ldsz  in  2  load size: 0 byte, 1 half, 2 word, 3 dword.
- mem_ldsext  in  1  sign-extend sub-width loads.
- MEM_ins_type  in  TYPE_W  tracking tag.
- MEM_ins_number  in  NUM_W  tracking tag.
- wb_stall  in  1  hold the WB register.
- wb_flush  in  1  invalidate the incoming entry.
- wb_valid  out  1  WB entry is valid.
- wb_wreg  out  1  register-file write enable.
- wb_destR  out  REG_AW  write index.
- wb_dest  out  DATA_W  write data.
- WB_ins_type  out  TYPE_W  registered tag.
- WB_ins_number  out  NUM_W  registered tag.
- wb_misalign  out  1  current WB entry is a misaligned load.
- wb_retire_cnt  out  CNT_W  retired-instruction count.

## Operation

- Pipeline register fields: valid, wreg, m2reg, destR, aluR, mdata, ldsz, ldsext, and both tags.
- Per rising clk, evaluated in priority order:
  - wb_flush=1: valid←0. All other fields still load from the MEM inputs, so tags stay visible. Flush wins over stall.
  - else wb_stall=1: all fields hold.
  - else: all fields load; valid←mem_valid.
- Offset: off = registered aluR[OFF_W-1:0].
- Load extraction (m2reg=1):
  - byte: mdata[8*off +: 8].
  - half: mdata[16*off[OFF_W-1:1] +: 16].
  - word: mdata[32*off[OFF_W-1:2] +: 32]. For DATA_W=32 this is the whole word.
  - dword: full mdata. Only meaningful when DATA_W=64; with DATA_W=32, ldsz=3 is treated as word.
  - Little-endian: offset 0 is the least significant byte.
  - Sign-extend from the field MSB when ldsext=1, else zero-extend. Extension applies to every field narrower than DATA_W.
- wb_dest is the extracted value when m2reg=1, else the registered aluR. It is combinational from the WB register only.
- wb_misalign = valid & m2reg & wreg & (half with off[0]≠0, or word with off[1:0]≠0, or dword with off[2:0]≠0).
- wb_wreg = valid & wreg & (destR≠0) & ~wb_misalign. Writes to r0 are always suppressed.
- Retire counter: increments on a rising edge when wb_valid=1 and wb_stall=0. A flushed or stalled entry counts at most once, when it leaves. The counter saturates at all-ones.

## Timing

- Latency: MEM inputs sampled at edge N appear on the WB outputs after edge N. One cycle, no combinational path from MEM inputs to outputs.
- wb_stall and wb_flush act on the same edge at which they are sampled.
- Reset (rst=0, asynchronous): every register and every output goes to 0, including wb_retire_cnt; wb_dest=0.
- Reset deasserts synchronously to clk at the system level. The first edge with rst=1 performs a normal load.
- Reset mid-stall discards the held entry; the counter is not incremented.
- Stall with valid=0: outputs hold; wb_wreg stays 0.

## Test plan

- Plain ALU writeback: mem_valid=1, wreg=1, m2reg=0, destR=5, aluR=0x12345678 → next cycle wb_wreg=1, wb_destR=5, wb_dest=0x12345678; the following edge (no stall) wb_retire_cnt=1.
- Byte/half extraction, DATA_W=32, mdata=0x80FF7F01:
  - lb, off=3 → 0xFFFFFF80.
  - lbu, off=3 → 0x00000080.
  - lh, off=2 → 0xFFFF80FF.
  - lhu, off=0 → 0x00007F01.
- Misalign: lh off=1 or lw off=2, wreg=1 → wb_misalign=1, wb_wreg=0, counter still increments on retirement.
- Stall/flush: load entry A, assert wb_stall for 3 cycles while inputs change → outputs stay A and the counter does not move. Assert stall+flush together → wb_valid=0 next cycle and wb_wreg=0.
- r0 and reset: destR=0, wreg=1 → wb_wreg=0. Drive rst=0 mid-cycle → all outputs 0 immediately, before the next edge.
- Saturation: CNT_W=4, retire 20 instructions → wb_retire_cnt=0xF. With DATA_W=64, ld (dword) off=0 → full mdata; lw off=4 signed → upper word sign-extended.

Source files
------------

// File: rtl/wb_stage_p.sv
// wb_stage_p: MEM/WB pipeline register with writeback-data formation.
// Holds the MEM-stage result with valid/stall/flush control, extracts
// sub-word loads with sign/zero extension, flags misaligned loads and
// keeps a saturating count of retired instructions.
module wb_stage_p #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int TYPE_W = 4,
  parameter int NUM_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_destR,
  input  logic [DATA_W-1:0] mem_aluR,
  input  logic [DATA_W-1:0] mem_mdata,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [1:0]        mem_ldsz,
  input  logic              mem_ldsext,
  input  logic [TYPE_W-1:0] MEM_ins_type,
  input  logic [NUM_W-1:0]  MEM_ins_number,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic [REG_AW-1:0] wb_destR,
  output logic [DATA_W-1:0] wb_dest,
  output logic [TYPE_W-1:0] WB_ins_type,
  output logic [NUM_W-1:0]  WB_ins_number,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  wb_retire_cnt
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              r_valid;
  logic              r_wreg;
  logic              r_m2reg;
  logic [REG_AW-1:0] r_destR;
  logic [DATA_W-1:0] r_aluR;
  logic [DATA_W-1:0] r_mdata;
  logic [1:0]        r_ldsz;
  logic              r_ldsext;
  logic [TYPE_W-1:0] r_type;
  logic [NUM_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_off_h;
  logic [OFF_W-1:0]  w_off_w;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_word_ext;
  logic [DATA_W-1:0] w_load;
  logic              w_misalign;

  // Pipeline register: flush invalidates but still loads (tags stay visible),
  // stall holds everything, otherwise a plain load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_destR  <= '0;
      r_aluR   <= '0;
      r_mdata  <= '0;
      r_ldsz   <= '0;
      r_ldsext <= 1'b0;
      r_type   <= '0;
      r_num    <= '0;
    end else if (wb_flush || !wb_stall) begin
      r_valid  <= wb_flush ? 1'b0 : mem_valid;
      r_wreg   <= mem_wreg;
      r_m2reg  <= mem_m2reg;
      r_destR  <= mem_destR;
      r_aluR   <= mem_aluR;
      r_mdata  <= mem_mdata;
      r_ldsz   <= mem_ldsz;
      r_ldsext <= mem_ldsext;
      r_type   <= MEM_ins_type;
      r_num    <= MEM_ins_number;
    end
  end

  // Retire counter: an entry counts when it leaves WB valid and unstalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_valid && !wb_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Byte offset and its half/word-aligned versions select the load lane.
  assign w_off   = r_aluR[OFF_W-1:0];
  assign w_off_h = w_off & ~OFF_W'(1);
  assign w_off_w = w_off & ~OFF_W'(3);

  assign w_byte = 8'(r_mdata >> {w_off, 3'b000});
  assign w_half = 16'(r_mdata >> {w_off_h, 3'b000});
  assign w_word = 32'(r_mdata >> {w_off_w, 3'b000});

  // A word load only needs extending when the datapath is wider than a word.
  generate
    if (DATA_W > 32) begin : g_wide
      assign w_word_ext = {{(DATA_W-32){r_ldsext & w_word[31]}}, w_word};
    end else begin : g_narrow
      assign w_word_ext = DATA_W'(w_word);
    end
  endgenerate

  // Load-data formation; dword is the full word (also on a 32-bit datapath).
  always_comb begin
    w_load = r_mdata;
    case (r_ldsz)
      2'd0:    w_load = {{(DATA_W-8){r_ldsext & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{(DATA_W-16){r_ldsext & w_half[15]}}, w_half};
      2'd2:    w_load = w_word_ext;
      default: w_load = r_mdata;
    endcase
  end

  // Misalignment is judged against the natural alignment of the access size.
  always_comb begin
    w_misalign = 1'b0;
    case (r_ldsz)
      2'd1:    w_misalign = w_off[0];
      2'd2:    w_misalign = |w_off[1:0];
      2'd3:    w_misalign = |w_off;
      default: w_misalign = 1'b0;
    endcase
  end

  assign wb_valid      = r_valid;
  assign wb_misalign   = r_valid & r_m2reg & r_wreg & w_misalign;
  assign wb_wreg       = r_valid & r_wreg & (r_destR != '0) & ~wb_misalign;
  assign wb_destR      = r_destR;
  assign wb_dest       = r_m2reg ? w_load : r_aluR;
  assign WB_ins_type   = r_type;
  assign WB_ins_number = r_num;
  assign wb_retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_stage_p.sv
// Testbench for wb_stage_p: a 32-bit instance (16-bit counter) and a
// 64-bit instance (4-bit counter) share stimulus and are checked against
// directed constants and a behavioural model of the writeback rules.
module tb_wb_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_valid, mem_wreg, mem_m2reg, mem_ldsext;
  logic [4:0]  mem_destR;
  logic [63:0] mem_aluR, mem_mdata;
  logic [1:0]  mem_ldsz;
  logic [3:0]  mem_type, mem_num;
  logic        wb_stall, wb_flush;

  logic        a_valid, a_wreg, a_mis;
  logic [4:0]  a_destR;
  logic [31:0] a_dest;
  logic [3:0]  a_type, a_num;
  logic [15:0] a_cnt;

  logic        b_valid, b_wreg, b_mis;
  logic [4:0]  b_destR;
  logic [63:0] b_dest;
  logic [3:0]  b_type, b_num;
  logic [3:0]  b_cnt;

  wb_stage_p u_a (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_destR(mem_destR),
    .mem_aluR(mem_aluR[31:0]), .mem_mdata(mem_mdata[31:0]),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_ldsz(mem_ldsz), .mem_ldsext(mem_ldsext),
    .MEM_ins_type(mem_type), .MEM_ins_number(mem_num),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .wb_valid(a_valid), .wb_wreg(a_wreg), .wb_destR(a_destR),
    .wb_dest(a_dest), .WB_ins_type(a_type), .WB_ins_number(a_num),
    .wb_misalign(a_mis), .wb_retire_cnt(a_cnt)
  );

  wb_stage_p #(.DATA_W(64), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_destR(mem_destR),
    .mem_aluR(mem_aluR), .mem_mdata(mem_mdata),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_ldsz(mem_ldsz), .mem_ldsext(mem_ldsext),
    .MEM_ins_type(mem_type), .MEM_ins_number(mem_num),
    .wb_stall(wb_stall), .wb_flush(wb_flush),
    .wb_valid(b_valid), .wb_wreg(b_wreg), .wb_destR(b_destR),
    .wb_dest(b_dest), .WB_ins_type(b_type), .WB_ins_number(b_num),
    .wb_misalign(b_mis), .wb_retire_cnt(b_cnt)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the WB entry and retire counts.
  logic        m_valid, m_wreg, m_m2reg, m_sext;
  logic [4:0]  m_destR;
  logic [63:0] m_alu, m_mdata;
  logic [1:0]  m_ldsz;
  logic [3:0]  m_type, m_num;
  int          m_cnt_a, m_cnt_b;

  function automatic int f_off(input int dw);
    return int'(m_alu[2:0]) % (dw / 8);
  endfunction

  function automatic logic [63:0] f_dest(input int dw);
    logic [63:0] mask, field;
    int off, w, base;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (!m_m2reg) return m_alu & mask;
    off = f_off(dw);
    case (m_ldsz)
      2'd0:    begin w = 8;  base = off;           end
      2'd1:    begin w = 16; base = off - off % 2; end
      2'd2:    begin w = 32; base = off - off % 4; end
      default: begin w = dw; base = 0;             end
    endcase
    field = m_mdata >> (8 * base);
    if (w < 64) field = field & ((64'd1 << w) - 64'd1);
    if (m_sext && (w < dw) && field[w-1]) field = field | (mask & ~((64'd1 << w) - 64'd1));
    return field & mask;
  endfunction

  function automatic logic f_mis(input int dw);
    int off;
    off = f_off(dw);
    return m_valid && m_m2reg && m_wreg &&
           ((m_ldsz == 2'd1 && off % 2 != 0) ||
            (m_ldsz == 2'd2 && off % 4 != 0) ||
            (m_ldsz == 2'd3 && off != 0));
  endfunction

  function automatic logic f_wreg(input int dw);
    return m_valid && m_wreg && (m_destR != 5'd0) && !f_mis(dw);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wreg = 0; m_m2reg = 0; m_sext = 0; m_destR = 0;
    m_alu = 0; m_mdata = 0; m_ldsz = 0; m_type = 0; m_num = 0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic set_in(input logic v, input logic wr, input logic m2r, input logic [4:0] dr,
                        input logic [63:0] alu, input logic [63:0] md, input logic [1:0] sz,
                        input logic sx);
    mem_valid = v; mem_wreg = wr; mem_m2reg = m2r; mem_destR = dr;
    mem_aluR = alu; mem_mdata = md; mem_ldsz = sz; mem_ldsext = sx;
  endtask

  // Advance the model with the current inputs, then clock the DUTs.
  task automatic tick();
    if (m_valid && !wb_stall) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 15) m_cnt_b++;
    end
    if (wb_flush || !wb_stall) begin
      m_valid = wb_flush ? 1'b0 : mem_valid;
      m_wreg = mem_wreg; m_m2reg = mem_m2reg; m_destR = mem_destR;
      m_alu = mem_aluR; m_mdata = mem_mdata; m_ldsz = mem_ldsz;
      m_sext = mem_ldsext; m_type = mem_type; m_num = mem_num;
    end
    @(posedge clk);
    #1;
    $display("[TB] t=%0t stall=%0b flush=%0b v=%0b sz=%0d a_dest=%h a_wreg=%0b a_cnt=%0d b_dest=%h b_cnt=%0d",
             $time, wb_stall, wb_flush, mem_valid, mem_ldsz, a_dest, a_wreg, a_cnt, b_dest, b_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_stall = 0; wb_flush = 0; mem_type = 0; mem_num = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 model_reset();
    tests_run++;
    if ({a_valid, a_wreg, a_destR, a_dest, a_type, a_num, a_mis, a_cnt} !== '0) begin
      tests_failed++; $display("FAIL reset_a: dest=%h cnt=%0d valid=%0b", a_dest, a_cnt, a_valid);
    end
    set_in(1, 1, 0, 5'd5, 64'h1234, 64'h55, 0, 0); mem_type = 4'h7;
    @(posedge clk); #1;
    tests_run++;
    if ({b_valid, b_wreg, b_destR, b_dest, b_type, b_num, b_mis, b_cnt} !== '0) begin
      tests_failed++; $display("FAIL reset_hold_b: dest=%h type=%h valid=%0b required 0", b_dest, b_type, b_valid);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_alu();
    set_in(1, 1, 0, 5'd5, 64'h0000_0000_1234_5678, 64'hDEAD_BEEF, 0, 0);
    tick();
    tests_run++;
    if (a_wreg !== 1'b1 || a_destR !== 5'd5 || a_dest !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL alu_wb: wreg=%0b destR=%0d dest=%h required 1/5/12345678", a_wreg, a_destR, a_dest);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests_run++;
    if (a_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL alu_retire: cnt=%0d required 1", a_cnt);
    end
  endtask

  task automatic test_extract();
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [63:0] off [4] = '{64'd3, 64'd3, 64'd2, 64'd0};
    logic        sx  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    logic [63:0] eb;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 1, 5'd3, {32'($urandom), 29'($urandom), 1'b0, 2'b00} | off[i],
             {32'($urandom), 32'h80FF_7F01}, sz[i], sx[i]);
      tick();
      eb = f_dest(64);
      tests_run++;
      if (a_dest !== exp[i] || a_wreg !== 1'b1) begin
        tests_failed++; $display("FAIL extract_a[%0d]: dest=%h wreg=%0b required %h/1", i, a_dest, a_wreg, exp[i]);
      end
      tests_run++;
      if (b_dest !== eb) begin
        tests_failed++; $display("FAIL extract_b[%0d]: dest=%h required %h", i, b_dest, eb);
      end
    end
  endtask

  task automatic test_dword();
    set_in(1, 1, 1, 5'd4, 64'd0, 64'h89AB_CDEF_0123_4567, 2'd3, 1'b1);
    tick();
    tests_run++;
    if (b_dest !== 64'h89AB_CDEF_0123_4567 || a_dest !== 32'h0123_4567 || a_mis !== 1'b0) begin
      tests_failed++; $display("FAIL dword_off0: b=%h a=%h a_mis=%0b", b_dest, a_dest, a_mis);
    end
    set_in(1, 1, 1, 5'd4, 64'd4, 64'h89AB_CDEF_0123_4567, 2'd2, 1'b1);
    tick();
    tests_run++;
    if (b_dest !== 64'hFFFF_FFFF_89AB_CDEF || b_mis !== 1'b0 || b_wreg !== 1'b1) begin
      tests_failed++; $display("FAIL lw_off4_b: dest=%h mis=%0b wreg=%0b required ffffffff89abcdef/0/1", b_dest, b_mis, b_wreg);
    end
    set_in(1, 1, 1, 5'd4, 64'd2, 64'h89AB_CDEF_0123_4567, 2'd3, 1'b0);
    tick();
    tests_run++;
    if (a_mis !== 1'b1 || b_mis !== 1'b1 || a_wreg !== 1'b0) begin
      tests_failed++; $display("FAIL dword_off2: a_mis=%0b b_mis=%0b a_wreg=%0b required 1/1/0", a_mis, b_mis, a_wreg);
    end
  endtask

  task automatic test_misalign();
    int c0;
    set_in(1, 1, 1, 5'd6, 64'd1, 64'h1111_2222_3333_4444, 2'd1, 1'b0);
    tick();
    c0 = m_cnt_a;
    tests_run++;
    if (a_mis !== 1'b1 || a_wreg !== 1'b0 || a_valid !== 1'b1) begin
      tests_failed++; $display("FAIL misalign_lh: mis=%0b wreg=%0b valid=%0b required 1/0/1", a_mis, a_wreg, a_valid);
    end
    set_in(1, 1, 1, 5'd6, 64'd2, 64'h1111_2222_3333_4444, 2'd2, 1'b0);
    tick();
    tests_run++;
    if (a_mis !== 1'b1 || a_wreg !== 1'b0 || a_cnt !== 16'(c0 + 1)) begin
      tests_failed++; $display("FAIL misalign_lw: mis=%0b wreg=%0b cnt=%0d required 1/0/%0d", a_mis, a_wreg, a_cnt, c0 + 1);
    end
  endtask

  task automatic test_r0();
    set_in(1, 1, 0, 5'd0, 64'hABCD, 64'd0, 2'd2, 1'b0);
    tick();
    tests_run++;
    if (a_wreg !== 1'b0 || b_wreg !== 1'b0 || a_valid !== 1'b1) begin
      tests_failed++; $display("FAIL r0_write: a_wreg=%0b b_wreg=%0b valid=%0b required 0/0/1", a_wreg, b_wreg, a_valid);
    end
  endtask

  task automatic test_stall_flush();
    int c0;
    set_in(1, 1, 0, 5'd7, 64'hCAFE_F00D, 64'd0, 2'd2, 1'b0);
    mem_type = 4'hA; mem_num = 4'h1;
    tick();
    c0 = m_cnt_a;
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 5'($urandom_range(1, 31)), {32'($urandom), 32'($urandom)}, 64'd0, 2'd2, 1'b0);
      mem_type = 4'($urandom); mem_num = 4'($urandom);
      tick();
      tests_run++;
      if (a_dest !== 32'hCAFE_F00D || a_destR !== 5'd7 || a_type !== 4'hA || a_num !== 4'h1 || a_cnt !== 16'(c0)) begin
        tests_failed++; $display("FAIL stall_hold[%0d]: dest=%h destR=%0d type=%h cnt=%0d required cafef00d/7/a/%0d",
                                 i, a_dest, a_destR, a_type, a_cnt, c0);
      end
    end
    wb_flush = 1'b1;
    set_in(1, 1, 0, 5'd9, 64'h1, 64'd0, 2'd2, 1'b0); mem_type = 4'hB; mem_num = 4'h3;
    tick();
    tests_run++;
    if (a_valid !== 1'b0 || a_wreg !== 1'b0 || a_type !== 4'hB || a_destR !== 5'd9 || a_cnt !== 16'(c0)) begin
      tests_failed++; $display("FAIL stall_flush: valid=%0b wreg=%0b type=%h destR=%0d cnt=%0d required 0/0/b/9/%0d",
                               a_valid, a_wreg, a_type, a_destR, a_cnt, c0);
    end
    wb_flush = 1'b0;
    set_in(1, 1, 0, 5'd10, 64'h2, 64'd0, 2'd2, 1'b0);
    tick();
    tests_run++;
    if (a_valid !== 1'b0 || a_wreg !== 1'b0 || a_type !== 4'hB) begin
      tests_failed++; $display("FAIL stall_invalid: valid=%0b wreg=%0b type=%h required 0/0/b", a_valid, a_wreg, a_type);
    end
    wb_stall = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tests_run++;
    if (a_cnt !== 16'(c0)) begin
      tests_failed++; $display("FAIL flushed_count: cnt=%0d required %0d", a_cnt, c0);
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 1, 1, 5'd12, 64'd0, 64'h7777_8888_9999_AAAA, 2'd3, 1'b0);
    tick();
    wb_stall = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1 model_reset();
    tests_run++;
    if ({a_valid, a_wreg, a_destR, a_dest, a_type, a_num, a_mis, a_cnt} !== '0 ||
        {b_valid, b_wreg, b_destR, b_dest, b_type, b_num, b_mis, b_cnt} !== '0) begin
      tests_failed++; $display("FAIL async_reset: a_dest=%h a_cnt=%0d b_dest=%h b_cnt=%0d required 0", a_dest, a_cnt, b_dest, b_cnt);
    end
    @(negedge clk); rst = 1'b1; wb_stall = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tests_run++;
    if (a_cnt !== 16'd0 || b_cnt !== 4'd0 || a_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_discard: a_cnt=%0d b_cnt=%0d valid=%0b required 0/0/0", a_cnt, b_cnt, a_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] ed;
    logic [31:0] ea;
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
             {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
             2'($urandom), 1'($urandom));
      mem_type = 4'($urandom); mem_num = 4'($urandom);
      wb_stall = ($urandom_range(0, 4) == 0);
      wb_flush = ($urandom_range(0, 9) == 0);
      tick();
      ed = f_dest(64);
      ea = ed[31:0];
      if (!m_m2reg || m_ldsz != 2'd3) ea = 32'(f_dest(32));
      else ea = m_mdata[31:0];
      tests_run++;
      if ({a_valid, a_wreg, a_destR, a_dest, a_type, a_num, a_mis, a_cnt} !==
          {m_valid, f_wreg(32), m_destR, ea, m_type, m_num, f_mis(32), 16'(m_cnt_a)}) begin
        tests_failed++; $display("FAIL random_a[%0d]: dest=%h wreg=%0b mis=%0b cnt=%0d required %h/%0b/%0b/%0d",
                                 i, a_dest, a_wreg, a_mis, a_cnt, ea, f_wreg(32), f_mis(32), m_cnt_a);
      end
      tests_run++;
      if ({b_valid, b_wreg, b_destR, b_dest, b_type, b_num, b_mis, b_cnt} !==
          {m_valid, f_wreg(64), m_destR, ed, m_type, m_num, f_mis(64), 4'(m_cnt_b)}) begin
        tests_failed++; $display("FAIL random_b[%0d]: dest=%h wreg=%0b mis=%0b cnt=%0d required %h/%0b/%0b/%0d",
                                 i, b_dest, b_wreg, b_mis, b_cnt, ed, f_wreg(64), f_mis(64), m_cnt_b);
      end
    end
    wb_stall = 1'b0; wb_flush = 1'b0;
  endtask

  task automatic test_saturation();
    #2 rst = 1'b0;
    #1 model_reset();
    @(negedge clk); rst = 1'b1;
    set_in(1, 1, 0, 5'd1, 64'd0, 64'd0, 0, 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) begin
        tests_run++;
        if (b_cnt !== 4'd10 || a_cnt !== 16'd10) begin
          tests_failed++; $display("FAIL count_10: a=%0d b=%0d required 10/10", a_cnt, b_cnt);
        end
      end
    end
    tests_run++;
    if (b_cnt !== 4'hF || a_cnt !== 16'd20) begin
      tests_failed++; $display("FAIL saturate: a=%0d b=%0d required 20/15", a_cnt, b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_extract();
    test_dword();
    test_misalign();
    test_r0();
    test_stall_flush();
    test_async_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
